// File: rtl/fetch_decode_buffer_pkg.sv
// fetch_decode_buffer_pkg: constants shared by fetch, decode and hazard logic.
package fetch_decode_buffer_pkg;
   localparam logic [31:0] NOP_INSTR = 32'h0;
   localparam int PC_INCR = 4;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/fetch_decode_buffer_sync_fifo_core.sv
// sync_fifo_core: generic in-order queue with synchronous clear and occupancy count.
module sync_fifo_core
   import fetch_decode_buffer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    clear,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic [clog2(DEPTH):0]   count,
   output logic                    full,
   output logic                    empty
);
   localparam int PW = clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic wr_en, rd_en;
   assign wr_en = push & ~full;
   assign rd_en = pop & ~empty;
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
   assign rdata = mem[rd_ptr];
   // storage needs no reset: nothing is visible until a pointer advances past it
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= wdata;
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(wr_en) - CW'(rd_en);
      end
   end
endmodule

// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: IF->ID queue of {PC, PC+4, instr} with stall absorption and flush.
module fetch_decode_buffer
   import fetch_decode_buffer_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    InValid,
   input  logic [ADDR_W-1:0]       InPC,
   input  logic [INST_W-1:0]       InInstr,
   output logic                    InReady,
   input  logic                    Flush,
   input  logic                    OutReady,
   output logic                    OutValid,
   output logic [ADDR_W-1:0]       OutPC,
   output logic [ADDR_W-1:0]       OutPCPlus4,
   output logic [INST_W-1:0]       OutInstr,
   output logic [clog2(DEPTH):0]   Count
);
   localparam int DW = 2 * ADDR_W + INST_W;
   logic [DW-1:0] head;
   logic full, empty, push, pop;
   assign InReady  = ~full;
   assign OutValid = ~empty;
   assign push     = InValid & InReady;
   assign pop      = OutValid & OutReady;
   sync_fifo_core #(.WIDTH(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (Clk),
      .rst_n (Reset),
      .push  (push),
      .pop   (pop),
      .clear (Flush),
      .wdata ({InPC, InPC + ADDR_W'(PC_INCR), InInstr}),
      .rdata (head),
      .count (Count),
      .full  (full),
      .empty (empty)
   );
   // empty head is masked so decode sees a NOP at PC 0 rather than stale storage
   assign OutPC      = OutValid ? head[DW-1 -: ADDR_W] : '0;
   assign OutPCPlus4 = OutValid ? head[INST_W +: ADDR_W] : '0;
   assign OutInstr   = OutValid ? head[INST_W-1:0] : INST_W'(NOP_INSTR);
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// tb_fetch_decode_buffer: directed vector table plus streaming push/pop sequence.
module tb_fetch_decode_buffer;
   logic        Clk = 0, Reset = 0, InValid = 0, Flush = 0, OutReady = 0;
   logic [31:0] InPC = 0, InInstr = 0;
   logic        InReady, OutValid;
   logic [31:0] OutPC, OutPCPlus4, OutInstr;
   logic [1:0]  Count;
   int          n_vec = 0, n_bad = 0;

   fetch_decode_buffer dut (
      .Clk(Clk), .Reset(Reset), .InValid(InValid), .InPC(InPC), .InInstr(InInstr),
      .InReady(InReady), .Flush(Flush), .OutReady(OutReady), .OutValid(OutValid),
      .OutPC(OutPC), .OutPCPlus4(OutPCPlus4), .OutInstr(OutInstr), .Count(Count)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      string       nm;
      logic        rst, iv;
      logic [31:0] pc, ins;
      logic        fl, ordy;
      logic [1:0]  cnt;
      logic        irdy, ov;
      logic [31:0] opc, op4, oins;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(string nm, logic rst, logic iv, logic [31:0] pc, logic [31:0] ins,
                              logic fl, logic ordy, logic [1:0] cnt, logic irdy, logic ov,
                              logic [31:0] opc, logic [31:0] op4, logic [31:0] oins);
      vec_t r;
      r.nm = nm; r.rst = rst; r.iv = iv; r.pc = pc; r.ins = ins; r.fl = fl; r.ordy = ordy;
      r.cnt = cnt; r.irdy = irdy; r.ov = ov; r.opc = opc; r.op4 = op4; r.oins = oins;
      return r;
   endfunction

   task automatic apply(input vec_t x);
      Reset = x.rst; InValid = x.iv; InPC = x.pc; InInstr = x.ins; Flush = x.fl; OutReady = x.ordy;
      @(posedge Clk);
      #1;
      n_vec++;
      if ({Count, InReady, OutValid, OutPC, OutPCPlus4, OutInstr} !==
          {x.cnt, x.irdy, x.ov, x.opc, x.op4, x.oins}) begin
         n_bad++;
         $display("FAIL %s: got cnt=%0d irdy=%b ov=%b pc=%h pc4=%h ins=%h, want cnt=%0d irdy=%b ov=%b pc=%h pc4=%h ins=%h",
                  x.nm, Count, InReady, OutValid, OutPC, OutPCPlus4, OutInstr,
                  x.cnt, x.irdy, x.ov, x.opc, x.op4, x.oins);
      end
   endtask

   initial begin
      logic [31:0] pc;
      //              name          rst iv pc            ins           fl ordy  cnt irdy ov opc           op4           oins
      tbl.push_back(v("rst0",        0, 1, 32'h40,       32'h11,       0, 1,    0,  1,  0, 0,            0,            0));
      tbl.push_back(v("rst1",        0, 1, 32'h40,       32'h11,       0, 1,    0,  1,  0, 0,            0,            0));
      tbl.push_back(v("rst2",        0, 1, 32'h40,       32'h11,       0, 1,    0,  1,  0, 0,            0,            0));
      tbl.push_back(v("push40",      1, 1, 32'h40,       32'h2008_0005,0, 1,    1,  1,  1, 32'h40,       32'h44,       32'h2008_0005));
      tbl.push_back(v("pop40",       1, 0, 32'h0,        32'h0,        0, 1,    0,  1,  0, 0,            0,            0));
      tbl.push_back(v("stall_p00",   1, 1, 32'h00,       32'hA0,       0, 0,    1,  1,  1, 32'h00,       32'h04,       32'hA0));
      tbl.push_back(v("stall_p04",   1, 1, 32'h04,       32'hA4,       0, 0,    2,  0,  1, 32'h00,       32'h04,       32'hA0));
      tbl.push_back(v("full_off08a", 1, 1, 32'h08,       32'hA8,       0, 0,    2,  0,  1, 32'h00,       32'h04,       32'hA0));
      tbl.push_back(v("full_off08b", 1, 1, 32'h08,       32'hA8,       0, 0,    2,  0,  1, 32'h00,       32'h04,       32'hA0));
      tbl.push_back(v("drain_04",    1, 1, 32'h08,       32'hA8,       0, 1,    1,  1,  1, 32'h04,       32'h08,       32'hA4));
      tbl.push_back(v("take08",      1, 1, 32'h08,       32'hA8,       0, 1,    1,  1,  1, 32'h08,       32'h0C,       32'hA8));
      tbl.push_back(v("drain_08",    1, 0, 32'h0,        32'h0,        0, 1,    0,  1,  0, 0,            0,            0));
      tbl.push_back(v("fl_p20",      1, 1, 32'h20,       32'hB0,       0, 0,    1,  1,  1, 32'h20,       32'h24,       32'hB0));
      tbl.push_back(v("fl_p24",      1, 1, 32'h24,       32'hB4,       0, 0,    2,  0,  1, 32'h20,       32'h24,       32'hB0));
      tbl.push_back(v("flush_full",  1, 1, 32'h80,       32'hC0,       1, 1,    0,  1,  0, 0,            0,            0));
      tbl.push_back(v("fl_p30",      1, 1, 32'h30,       32'hB8,       0, 0,    1,  1,  1, 32'h30,       32'h34,       32'hB8));
      tbl.push_back(v("flush_push",  1, 1, 32'h84,       32'hC4,       1, 1,    0,  1,  0, 0,            0,            0));
      tbl.push_back(v("post_flush",  1, 0, 32'h0,        32'h0,        0, 0,    0,  1,  0, 0,            0,            0));
      tbl.push_back(v("push200",     1, 1, 32'h200,      32'hD0,       0, 0,    1,  1,  1, 32'h200,      32'h204,      32'hD0));
      tbl.push_back(v("pop200",      1, 0, 32'h0,        32'h0,        0, 1,    0,  1,  0, 0,            0,            0));
      tbl.push_back(v("wrap_pc4",    1, 1, 32'hFFFF_FFFC,32'hE0,       0, 0,    1,  1,  1, 32'hFFFF_FFFC,32'h0,        32'hE0));
      tbl.push_back(v("p300",        1, 1, 32'h300,      32'hE4,       0, 0,    2,  0,  1, 32'hFFFF_FFFC,32'h0,        32'hE0));
      tbl.push_back(v("rst_full",    0, 1, 32'h304,      32'hE8,       0, 0,    0,  1,  0, 0,            0,            0));
      tbl.push_back(v("rst_release", 1, 0, 32'h0,        32'h0,        0, 0,    0,  1,  0, 0,            0,            0));
      tbl.push_back(v("push400",     1, 1, 32'h400,      32'hF0,       0, 0,    1,  1,  1, 32'h400,      32'h404,      32'hF0));
      tbl.push_back(v("pop400",      1, 0, 32'h0,        32'h0,        0, 1,    0,  1,  0, 0,            0,            0));
      foreach (tbl[i]) apply(tbl[i]);
      apply(v("p10",  1, 1, 32'h10, 32'h10 ^ 32'hDEAD_0000, 0, 0, 1, 1, 1, 32'h10, 32'h14, 32'h10 ^ 32'hDEAD_0000));
      apply(v("pp14", 1, 1, 32'h14, 32'h14 ^ 32'hDEAD_0000, 0, 1, 1, 1, 1, 32'h14, 32'h18, 32'h14 ^ 32'hDEAD_0000));
      for (int i = 0; i < 100; i++) begin
         pc = 32'h18 + 32'(4 * i);
         apply(v("stream", 1, 1, pc, pc ^ 32'hDEAD_0000, 0, 1, 1, 1, 1, pc, pc + 32'd4, pc ^ 32'hDEAD_0000));
      end
      apply(v("stream_end", 1, 0, 32'h0, 32'h0, 0, 1, 0, 1, 0, 0, 0, 0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
